// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode decoupling FIFO. It carries {instr, pc, pc+4} in program order.
// Its ready output back-pressures the fetch PC, and a redirect empties it.
module fetch_decode_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [XLEN-1:0]          In_Instr,
    input  logic [XLEN-1:0]          In_PC,
    input  logic [XLEN-1:0]          In_PC_Plus_4,
    input  logic                     Flush,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [XLEN-1:0]          Out_Instr,
    output logic [XLEN-1:0]          Out_PC,
    output logic [XLEN-1:0]          Out_PC_Plus_4,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic   full, empty, push, pop;
    entry_t head;

    // Ready depends only on registered occupancy, so decode's Out_Ready never
    // reaches the fetch PC enable combinationally.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        In_Ready  = ~full;
        Out_Valid = ~empty;
        push      = In_Valid & In_Ready & ~Flush;
        pop       = Out_Valid & Out_Ready & ~Flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PW bits wide and DEPTH is a power of two, so they wrap for free.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (push && RST_N) begin
            mem_d[wr_ptr_q].instr     = In_Instr;
            mem_d[wr_ptr_q].pc        = In_PC;
            mem_d[wr_ptr_q].pc_plus_4 = In_PC_Plus_4;
        end
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
        if (empty) begin
            Out_Instr     = NOP;
            Out_PC        = '0;
            Out_PC_Plus_4 = '0;
        end else begin
            Out_Instr     = head.instr;
            Out_PC        = head.pc;
            Out_PC_Plus_4 = head.pc_plus_4;
        end
    end

    assign Count = count_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; a reset cycle never writes it.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert (!(push && full))  else $error("queue push while full");
            assert (!(pop && empty))  else $error("queue pop while empty");
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=2): reset, stream, fill, wrap, flush, reset mid-run.
module tb_fetch_decode_queue;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] In_Instr;
    logic [31:0] In_PC;
    logic [31:0] In_PC_Plus_4;
    logic        Flush;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Instr;
    logic [31:0] Out_PC;
    logic [31:0] Out_PC_Plus_4;
    logic [1:0]  Count;

    int checks = 0;
    int errors = 0;

    fetch_decode_queue #(.DEPTH(2), .XLEN(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Instr(In_Instr), .In_PC(In_PC), .In_PC_Plus_4(In_PC_Plus_4),
        .Flush(Flush),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Instr(Out_Instr), .Out_PC(Out_PC), .Out_PC_Plus_4(Out_PC_Plus_4),
        .Count(Count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic drive_pc(input logic [31:0] pc);
        In_PC        = pc;
        In_Instr     = instr_of(pc);
        In_PC_Plus_4 = pc + 32'd4;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(Out_Valid), 32'd1);
        chk({tag, "_pc"}, Out_PC, pc);
        chk({tag, "_instr"}, Out_Instr, instr_of(pc));
        chk({tag, "_pc4"}, Out_PC_Plus_4, pc + 32'd4);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"}, 32'(Count), 32'd0);
        chk({tag, "_valid"}, 32'(Out_Valid), 32'd0);
        chk({tag, "_instr"}, Out_Instr, 32'h0000_0013);
        chk({tag, "_pc"}, Out_PC, 32'd0);
        chk({tag, "_pc4"}, Out_PC_Plus_4, 32'd0);
        chk({tag, "_inrdy"}, 32'(In_Ready), 32'd1);
    endtask

    initial begin
        // 1. reset held two cycles with fetch presenting an instruction
        RST_N = 1'b0; In_Valid = 1'b1; Out_Ready = 1'b0; Flush = 1'b0;
        drive_pc(32'h100);
        step();
        step();
        chk_empty("reset");

        // 2. continuous streaming: each PC appears one cycle after it is pushed
        RST_N = 1'b1; Out_Ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_pc(32'(4 * k));
            step();
            chk_head("stream", 32'(4 * k));
            chk("stream_count", 32'(Count), 32'd1);
            chk("stream_inrdy", 32'(In_Ready), 32'd1);
        end
        In_Valid = 1'b0;
        step();
        chk_empty("stream_drain");

        // 3. fill with decode stalled; third push refused, head held stable
        Out_Ready = 1'b0; In_Valid = 1'b1;
        drive_pc(32'h0);
        step();
        chk("fill1_count", 32'(Count), 32'd1);
        chk_head("fill1", 32'h0);
        drive_pc(32'h4);
        step();
        chk("fill2_count", 32'(Count), 32'd2);
        chk("fill2_inrdy", 32'(In_Ready), 32'd0);
        chk_head("fill2", 32'h0);
        drive_pc(32'h8);
        step();
        chk("fill3_count", 32'(Count), 32'd2);
        chk("fill3_inrdy", 32'(In_Ready), 32'd0);
        chk_head("fill3_hold", 32'h0);

        // 4. drain with wrap: full pop frees a slot, push resumes the cycle after
        Out_Ready = 1'b1;
        step();
        chk("drain1_count", 32'(Count), 32'd1);
        chk("drain1_inrdy", 32'(In_Ready), 32'd1);
        chk_head("drain1", 32'h4);
        step();
        chk("drain2_count", 32'(Count), 32'd1);
        chk_head("drain2", 32'h8);
        drive_pc(32'hC);
        step();
        chk("drain3_count", 32'(Count), 32'd1);
        chk_head("drain3", 32'hC);
        In_Valid = 1'b0;
        step();
        chk_empty("drain_end");

        // 5. flush while full drops everything including this cycle's offer
        Out_Ready = 1'b0; In_Valid = 1'b1;
        drive_pc(32'h20);
        step();
        drive_pc(32'h24);
        step();
        chk("flpre_count", 32'(Count), 32'd2);
        Flush = 1'b1;
        drive_pc(32'h40);
        #1;
        chk("fl_inrdy_full", 32'(In_Ready), 32'd0);
        step();
        chk_empty("flush");
        Flush = 1'b0;
        drive_pc(32'h80);
        step();
        chk("flpost_count", 32'(Count), 32'd1);
        chk_head("flpost", 32'h80);
        In_Valid = 1'b0; Out_Ready = 1'b1;
        step();
        chk_empty("flpost_drain");

        // 5b. flush at occupancy 1 with push and pop both offered
        In_Valid = 1'b1; Out_Ready = 1'b0;
        drive_pc(32'h90);
        step();
        Out_Ready = 1'b1; Flush = 1'b1;
        drive_pc(32'h94);
        step();
        chk_empty("flush1");
        Flush = 1'b0;

        // 6. reset mid-operation overrides push, pop and flush
        Out_Ready = 1'b0; In_Valid = 1'b1;
        drive_pc(32'h200);
        step();
        drive_pc(32'h204);
        step();
        chk("rstpre_count", 32'(Count), 32'd2);
        RST_N = 1'b0; Out_Ready = 1'b1; Flush = 1'b1;
        drive_pc(32'h208);
        step();
        chk_empty("rst_mid");
        RST_N = 1'b1; Flush = 1'b0;
        drive_pc(32'h300);
        step();
        chk("rstpost1_count", 32'(Count), 32'd1);
        chk_head("rstpost1", 32'h300);
        drive_pc(32'h304);
        step();
        chk("rstpost2_count", 32'(Count), 32'd1);
        chk_head("rstpost2", 32'h304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
